decade_down_timer: RTL and testbench

DECADE_DOWN_TIMER -- requirements
Module: decade_down_timer

---
 rtl/decade_pkg.sv | 17 +
 rtl/bcd_digit_down.sv | 24 ++
 rtl/decade_down_timer.sv | 168 ++++++++++++++++
 tb/tb_decade_down_timer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decade_pkg.sv
// Shared definitions for the cascaded BCD down-timer: decade geometry and
// the controller state encoding.
package decade_pkg;

    // Width of one BCD decade and the largest legal digit value.
    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Controller states. DONE is a single-cycle terminal-count state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : decade_pkg

// File: rtl/bcd_digit_down.sv
// One BCD decade of the down-counter. Purely combinational: given the current
// digit and an incoming borrow, produce the decremented digit and the borrow
// for the next decade. With borrow_in low the digit passes through unchanged,
// which lets the top level reuse this cell to validate loaded digits.
module bcd_digit_down
    import decade_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] next_digit,
    output logic             borrow_out,
    output logic             is_zero,
    output logic             invalid
);

    assign is_zero    = (digit == '0);
    assign invalid    = (digit > BCD_MAX);

    // A zero digit that is asked to decrement wraps to nine and borrows onward.
    assign borrow_out = borrow_in & is_zero;
    assign next_digit = !borrow_in ? digit
                      : (is_zero ? BCD_MAX : (digit - 4'd1));

endmodule : bcd_digit_down

// File: rtl/decade_down_timer.sv
// Cascaded BCD down-timer with load / start / pause control.
// A chain of bcd_digit_down cells computes either the decremented count or,
// while load is asserted, passes load_val through so its digits can be
// validated by the same cells. A four-state controller decides what the
// registered count does on each edge; busy, done and err are registered.
module decade_down_timer
    import decade_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    input  logic                    start,
    input  logic                    pause,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int W = BCD_W * DIGITS;

    state_t         r_state;
    logic [W-1:0]   r_count;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    state_t         w_state_nxt;
    logic [W-1:0]   w_count_nxt;
    logic           w_err_nxt;

    logic [W-1:0]   w_digit_in;
    logic [W-1:0]   w_digit_out;
    logic [DIGITS:0]   w_borrow;
    logic [DIGITS-1:0] w_is_zero;
    logic [DIGITS-1:0] w_invalid;

    logic           w_load_ok;
    logic           w_load_bad;
    logic           w_count_zero;
    logic           w_can_dec;
    logic           w_dec_hits_zero;

    // While load is high the cells see load_val with no borrow injected, so
    // next_digit mirrors load_val and invalid flags any digit above nine.
    // Otherwise they see the count with a borrow into the least digit, which
    // yields count - 1 in BCD.
    assign w_digit_in = load ? load_val : r_count;
    assign w_borrow[0] = ~load;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_down u_digit (
                .digit      (w_digit_in[g*BCD_W +: BCD_W]),
                .borrow_in  (w_borrow[g]),
                .next_digit (w_digit_out[g*BCD_W +: BCD_W]),
                .borrow_out (w_borrow[g+1]),
                .is_zero    (w_is_zero[g]),
                .invalid    (w_invalid[g])
            );
        end
    endgenerate

    assign w_load_ok  = load & ~(|w_invalid);
    assign w_load_bad = load &  (|w_invalid);

    // The signals below are only meaningful when load is low, which is the
    // only case in which the controller consults them (load has priority).
    assign w_count_zero    = &w_is_zero;
    // A borrow out of the top decade means the count is zero; refusing that
    // decrement keeps the count from ever wrapping to all nines.
    assign w_can_dec       = ~w_borrow[DIGITS];
    assign w_dec_hits_zero = (w_digit_out == '0);

    // Next-state and next-count decode, priority load > start > pause > decrement.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned and infer a latch.
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_err_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (load) begin
                    if (w_load_ok) w_count_nxt = w_digit_out;
                    else           w_err_nxt   = 1'b1;
                end else if (start) begin
                    if (w_count_zero) w_err_nxt   = 1'b1;
                    else              w_state_nxt = RUN;
                end
            end

            RUN: begin
                if (load) begin
                    // A valid load aborts the run; no done pulse is produced.
                    if (w_load_ok) begin
                        w_count_nxt = w_digit_out;
                        w_state_nxt = IDLE;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (pause) begin
                    w_state_nxt = HOLD;
                end else if (en && w_can_dec) begin
                    // start held high while running is simply not a request here.
                    w_count_nxt = w_digit_out;
                    if (w_dec_hits_zero) w_state_nxt = DONE;
                end
            end

            HOLD: begin
                if (load) begin
                    if (w_load_ok) w_count_nxt = w_digit_out;
                    else           w_err_nxt   = 1'b1;
                end else if (start) begin
                    // A count zeroed by a load while held cannot be resumed.
                    if (w_count_zero) w_err_nxt   = 1'b1;
                    else              w_state_nxt = RUN;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Controller state and count registers.
    always_ff @(posedge clock or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == RUN) || (w_state_nxt == HOLD);
            r_done <= (w_state_nxt == DONE);
            r_err  <= w_err_nxt;
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule : decade_down_timer

// File: tb/tb_decade_down_timer.sv
// Directed bench for decade_down_timer (DIGITS = 2). Each task drives one
// scenario and compares {busy, done, err, count} against hand-derived values.
module tb_decade_down_timer;

    logic       clock;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       err;

    int vectors    = 0;
    int miscompares = 0;

    decade_down_timer #(.DIGITS(2)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Status word layout: {busy, done, err, count[7:0]}.
    function automatic logic [10:0] status();
        return {busy, done, err, count};
    endfunction

    // Two-digit BCD encoding of 0..99.
    function automatic logic [7:0] bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        #3;
        obs = status();
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_state: got %h, expected %h", obs, 11'h000);
        end
        @(negedge clock);
        rst_n = 1'b1;
        step();
        obs = status();
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL after_reset_idle: got %h, expected %h", obs, 11'h000);
        end
    endtask

    // Load 12 and run with en=1: count 11..00, done coincides with 00 on the
    // 12th edge after the start edge (13th cycle counting the start cycle).
    task automatic test_countdown();
        logic [10:0] obs;
        logic [10:0] exp;
        do_load(8'h12);
        obs = status();
        vectors++;
        if (obs !== {3'b000, 8'h12}) begin
            miscompares++;
            $display("FAIL load_12: got %h, expected %h", obs, {3'b000, 8'h12});
        end
        en    = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        obs = status();
        vectors++;
        if (obs !== {3'b100, 8'h12}) begin
            miscompares++;
            $display("FAIL start_no_dec: got %h, expected %h", obs, {3'b100, 8'h12});
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = (k == 12) ? {3'b010, 8'h00} : {3'b100, bcd(12 - k)};
            obs = status();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL countdown_k%0d: got %h, expected %h", k, obs, exp);
            end
        end
        step();
        obs = status();
        vectors++;
        if (obs !== {3'b000, 8'h00}) begin
            miscompares++;
            $display("FAIL done_to_idle: got %h, expected %h", obs, {3'b000, 8'h00});
        end
        en = 1'b0;
    endtask

    // Load 05, en alternates 1/0 starting with 1: decrements on odd edges,
    // done on the 9th edge after start (10th cycle counting the start cycle).
    task automatic test_en_toggle();
        logic [10:0] obs;
        logic [10:0] exp;
        do_load(8'h05);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            en = (k % 2 == 1);
            step();
            exp = (k == 9) ? {3'b010, 8'h00} : {3'b100, bcd(5 - (k + 1) / 2)};
            obs = status();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL en_toggle_k%0d: got %h, expected %h", k, obs, exp);
            end
        end
        en = 1'b0;
        step();
    endtask

    // Run down to 07, pause for three edges (second and third pauses land in
    // HOLD and are ignored), then resume and see 06.
    task automatic test_pause_resume();
        logic [10:0] obs;
        do_load(8'h09);
        start = 1'b1;
        step();
        start = 1'b0;
        en    = 1'b1;
        step();
        step();
        obs = status();
        vectors++;
        if (obs !== {3'b100, 8'h07}) begin
            miscompares++;
            $display("FAIL run_at_07: got %h, expected %h", obs, {3'b100, 8'h07});
        end
        pause = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            obs = status();
            vectors++;
            if (obs !== {3'b100, 8'h07}) begin
                miscompares++;
                $display("FAIL hold_p%0d: got %h, expected %h", k, obs, {3'b100, 8'h07});
            end
        end
        pause = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        obs = status();
        vectors++;
        if (obs !== {3'b100, 8'h07}) begin
            miscompares++;
            $display("FAIL resume_edge: got %h, expected %h", obs, {3'b100, 8'h07});
        end
        step();
        obs = status();
        vectors++;
        if (obs !== {3'b100, 8'h06}) begin
            miscompares++;
            $display("FAIL resume_06: got %h, expected %h", obs, {3'b100, 8'h06});
        end
        en = 1'b0;
        do_load(8'h00);
        obs = status();
        vectors++;
        if (obs !== {3'b000, 8'h00}) begin
            miscompares++;
            $display("FAIL abort_to_00: got %h, expected %h", obs, {3'b000, 8'h00});
        end
    endtask

    // Invalid load digits and start with a zero count are both rejected with
    // a one-cycle err pulse and no change to count or state.
    task automatic test_errors();
        logic [10:0] obs;
        do_load(8'h3A);
        obs = status();
        vectors++;
        if (obs !== {3'b001, 8'h00}) begin
            miscompares++;
            $display("FAIL bad_load_3a: got %h, expected %h", obs, {3'b001, 8'h00});
        end
        step();
        obs = status();
        vectors++;
        if (obs !== {3'b000, 8'h00}) begin
            miscompares++;
            $display("FAIL err_one_cycle: got %h, expected %h", obs, {3'b000, 8'h00});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        obs = status();
        vectors++;
        if (obs !== {3'b001, 8'h00}) begin
            miscompares++;
            $display("FAIL start_zero: got %h, expected %h", obs, {3'b001, 8'h00});
        end
        step();
        obs = status();
        vectors++;
        if (obs !== {3'b000, 8'h00}) begin
            miscompares++;
            $display("FAIL start_zero_idle: got %h, expected %h", obs, {3'b000, 8'h00});
        end
        do_load(8'hA3);
        obs = status();
        vectors++;
        if (obs !== {3'b001, 8'h00}) begin
            miscompares++;
            $display("FAIL bad_load_a3: got %h, expected %h", obs, {3'b001, 8'h00});
        end
        do_load(8'h99);
        obs = status();
        vectors++;
        if (obs !== {3'b000, 8'h99}) begin
            miscompares++;
            $display("FAIL load_99: got %h, expected %h", obs, {3'b000, 8'h99});
        end
    endtask

    // In RUN at 40, a load of 99 aborts to IDLE with no done pulse.
    task automatic test_load_abort();
        logic [10:0] obs;
        do_load(8'h41);
        en    = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        obs = status();
        vectors++;
        if (obs !== {3'b100, 8'h40}) begin
            miscompares++;
            $display("FAIL run_at_40: got %h, expected %h", obs, {3'b100, 8'h40});
        end
        do_load(8'h99);
        obs = status();
        vectors++;
        if (obs !== {3'b000, 8'h99}) begin
            miscompares++;
            $display("FAIL abort_load_99: got %h, expected %h", obs, {3'b000, 8'h99});
        end
        step();
        obs = status();
        vectors++;
        if (obs !== {3'b000, 8'h99}) begin
            miscompares++;
            $display("FAIL abort_no_done: got %h, expected %h", obs, {3'b000, 8'h99});
        end
        en = 1'b0;
    endtask

    // Reset mid-RUN at 25 clears everything between edges; operation resumes
    // on the first edge after release.
    task automatic test_async_reset();
        logic [10:0] obs;
        do_load(8'h26);
        en    = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        obs = status();
        vectors++;
        if (obs !== {3'b100, 8'h25}) begin
            miscompares++;
            $display("FAIL run_at_25: got %h, expected %h", obs, {3'b100, 8'h25});
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = status();
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL async_reset: got %h, expected %h", obs, 11'h000);
        end
        #2;
        rst_n = 1'b1;
        step();
        obs = status();
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %h, expected %h", obs, 11'h000);
        end
        en = 1'b0;
        do_load(8'h08);
        obs = status();
        vectors++;
        if (obs !== {3'b000, 8'h08}) begin
            miscompares++;
            $display("FAIL post_reset_load: got %h, expected %h", obs, {3'b000, 8'h08});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        start    = 1'b0;
        pause    = 1'b0;

        test_reset();
        test_countdown();
        test_en_toggle();
        test_pause_resume();
        test_errors();
        test_load_abort();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_decade_down_timer
